// File: rtl/writer_pkg.sv
// Shared types and register map for the sprite display register writer.
// Request record, drain FSM states and display register addresses.
package writer_pkg;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_req_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [8:0] DINO_X     = 9'd0;
    localparam logic [8:0] DINO_Y     = 9'd1;
    localparam logic [8:0] CACTUS_X   = 9'd2;
    localparam logic [8:0] CACTUS_Y   = 9'd3;
    localparam logic [8:0] PTERO_X    = 9'd4;
    localparam logic [8:0] PTERO_Y    = 9'd5;
    localparam logic [8:0] METEOR_X   = 9'd6;
    localparam logic [8:0] METEOR_Y   = 9'd7;
    localparam logic [8:0] GODZILLA_X = 9'd8;
    localparam logic [8:0] GODZILLA_Y = 9'd9;
    localparam logic [8:0] SCORE      = 9'd10;
    localparam logic [8:0] SCORE_X    = 9'd11;
    localparam logic [8:0] SCORE_Y    = 9'd12;

endpackage

// File: rtl/writer_fifo.sv
// First-word-fall-through request FIFO; head is visible combinationally, push/pop take effect at the edge.
// Push while full and pop while empty are ignored; the caller gates them with full/empty.
module writer_fifo
    import writer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  wr_req_t                   push_dat,
    input  logic                      pop,
    output wr_req_t                   pop_dat,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    // Extra pointer bit separates the full and empty cases when indices match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wr_req_t     mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/vga_reg_writer.sv
// Buffers sprite/score register updates and issues them as one-cycle writes on the display register bus.
// WRITER_BLANK_GATE_EN: drain only from vsync start, capped per frame, with sticky backlog; otherwise drain continuously.
module vga_reg_writer
    import writer_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int MAX_PER_FRAME = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [8:0]                  req_addr,
    input  logic [31:0]                 req_data,
    input  logic                        vga_vs,
    output logic                        chipselect,
    output logic                        write,
    output logic [8:0]                  address,
    output logic [31:0]                 writedata,
    output logic [$clog2(DEPTH+1)-1:0]  pending,
    output logic                        backlog,
    input  logic                        clear_backlog
);

    localparam int PW = $clog2(DEPTH + 1);

    wr_req_t head;
    wr_req_t push_req;
    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_push;
    logic    pop;

    assign push_req  = '{addr: req_addr, data: req_data};
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;

    writer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (push_req),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (pending)
    );

`ifdef WRITER_BLANK_GATE_EN
    localparam int CW = $clog2(MAX_PER_FRAME + 1);

    state_t        state;
    state_t        nxt_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt_cnt;
    logic          vs_q;
    logic          vs_edge;
    logic          empty_after;
    logic          set_backlog;

    assign vs_edge = vs_q && !vga_vs;
    // A pop with no simultaneous push drains the last entry.
    assign empty_after = (pending == PW'(1)) && !fifo_push;

    always_comb begin
        pop         = 1'b0;
        nxt_state   = state;
        nxt_cnt     = cnt;
        set_backlog = 1'b0;
        case (state)
            IDLE: begin
                if (vs_edge && !fifo_empty) begin
                    pop     = 1'b1;
                    nxt_cnt = CW'(1);
                end
            end
            DRAIN: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    nxt_cnt = cnt + 1'b1;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (pop) begin
            if (empty_after) begin
                nxt_state = IDLE;
            end else if (nxt_cnt == CW'(MAX_PER_FRAME)) begin
                nxt_state   = IDLE;
                set_backlog = 1'b1;
            end else begin
                nxt_state = DRAIN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            vs_q    <= 1'b1;
            backlog <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            vs_q  <= vga_vs;
            if (set_backlog)
                backlog <= 1'b1;
            else if (clear_backlog)
                backlog <= 1'b0;
        end
    end
`else
    localparam logic [31:0] MPF_VEC = 32'(MAX_PER_FRAME);

    logic unused_cfg;

    assign unused_cfg = ^{vga_vs, clear_backlog, MPF_VEC};
    assign pop        = !fifo_empty;
    assign backlog    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chipselect <= 1'b0;
            address    <= '0;
            writedata  <= '0;
        end else begin
            chipselect <= pop;
            if (pop) begin
                address   <= head.addr;
                writedata <= head.data;
            end
        end
    end

    assign write = chipselect;

endmodule

// File: tb/tb_vga_reg_writer.sv
// Self-checking bench for vga_reg_writer: scoreboard on every strobe plus table rows and timing sequences.
// Covers both the vsync-gated (WRITER_BLANK_GATE_EN) and free-running builds.
module tb_vga_reg_writer;
    import writer_pkg::*;

    localparam int DEPTH = 16;
    localparam int MPF   = 4;
    localparam int PW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [8:0]    req_addr;
    logic [31:0]   req_data;
    logic          vga_vs;
    logic          chipselect;
    logic          write;
    logic [8:0]    address;
    logic [31:0]   writedata;
    logic [PW-1:0] pending;
    logic          backlog;
    logic          clear_backlog;

    vga_reg_writer #(.DEPTH(DEPTH), .MAX_PER_FRAME(MPF)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .vga_vs        (vga_vs),
        .chipselect    (chipselect),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .pending       (pending),
        .backlog       (backlog),
        .clear_backlog (clear_backlog)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    int      strobe_cnt = 0;
    wr_req_t sb_q[$];

    typedef struct {
        int n_push;
        bit clr;
        int exp_strobes;
        int exp_pending;
        bit exp_backlog;
    } row_t;

    row_t rows[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic push_one(input logic [8:0] a, input logic [31:0] d);
        int guard;
        guard = 0;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        while (!req_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("push_ready", req_ready, 1);
        @(posedge clk);
        sb_q.push_back('{addr: a, data: d});
        #1;
        req_valid = 1'b0;
    endtask

`ifdef WRITER_BLANK_GATE_EN
    task automatic vsync_pulse();
        vga_vs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vga_vs = 1'b1;
    endtask
`endif

    always @(negedge clk) begin
        if (!reset && chipselect) begin
            wr_req_t e;
            strobe_cnt++;
            chk("write_eq_cs", write, 1);
            chk("sb_nonempty", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("strobe_addr", address, e.addr);
                chk("strobe_data", writedata, e.data);
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int nacc;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_data      = '0;
        vga_vs        = 1'b1;
        clear_backlog = 1'b0;
`ifdef WRITER_BLANK_GATE_EN
        rows[0] = '{3, 1'b0, 3, 0, 1'b0};
        rows[1] = '{6, 1'b0, 4, 2, 1'b1};
        rows[2] = '{0, 1'b0, 2, 0, 1'b1};
        rows[3] = '{0, 1'b1, 0, 0, 1'b0};
        rows[4] = '{5, 1'b0, 4, 1, 1'b1};
        rows[5] = '{3, 1'b1, 4, 0, 1'b0};
`else
        rows[0] = '{3, 1'b0, 3, 0, 1'b0};
        rows[1] = '{6, 1'b0, 6, 0, 1'b0};
        rows[2] = '{0, 1'b0, 0, 0, 1'b0};
        rows[3] = '{1, 1'b1, 1, 0, 1'b0};
        rows[4] = '{16, 1'b0, 16, 0, 1'b0};
        rows[5] = '{2, 1'b0, 2, 0, 1'b0};
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_chipselect", chipselect, 0);
        chk("rst_write", write, 0);
        chk("rst_address", address, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_backlog", backlog, 0);
        chk("rst_pending", pending, 0);
        chk("rst_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

`ifdef WRITER_BLANK_GATE_EN
        // First strobe lands the cycle after the vsync edge, then back-to-back.
        strobe_cnt = 0;
        push_one(9'd0, 32'd100);
        push_one(9'd1, 32'd50);
        push_one(9'd10, 32'd7);
        chk("t1_pending3", pending, 3);
        chk("t1_no_early_strobe", strobe_cnt, 0);
        vga_vs = 1'b0;
        @(negedge clk); chk("t1_edge_cycle_idle", chipselect, 0);
        @(negedge clk); chk("t1_strobe1", chipselect, 1);
        @(negedge clk); chk("t1_strobe2", chipselect, 1);
        @(negedge clk); chk("t1_strobe3", chipselect, 1);
        @(negedge clk); #1;
        chk("t1_after", chipselect, 0);
        chk("t1_count", strobe_cnt, 3);
        chk("t1_pending0", pending, 0);
        chk("t1_backlog", backlog, 0);
        @(posedge clk);
        #1;
        vga_vs = 1'b1;
`else
        // Entry pushed at edge k strobes in the cycle after edge k+1.
        strobe_cnt = 0;
        push_one(9'd4, 32'd200);
        @(negedge clk);
        chk("nb_cycle_k", write, 0);
        @(negedge clk);
        chk("nb_write", write, 1);
        chk("nb_address", address, 4);
        chk("nb_writedata", writedata, 200);
        @(posedge clk);
        #1;
`endif

        for (int r = 0; r < 6; r++) begin
            strobe_cnt = 0;
            if (rows[r].clr) begin
                clear_backlog = 1'b1;
                @(posedge clk);
                #1;
                clear_backlog = 1'b0;
            end
            for (int i = 0; i < rows[r].n_push; i++)
                push_one(9'($urandom_range(0, 12)), $urandom);
`ifdef WRITER_BLANK_GATE_EN
            vsync_pulse();
`endif
            repeat (8) @(posedge clk);
            @(negedge clk);
            #1;
            chk($sformatf("row%0d_strobes", r), strobe_cnt, rows[r].exp_strobes);
            chk($sformatf("row%0d_pending", r), pending, rows[r].exp_pending);
            chk($sformatf("row%0d_backlog", r), backlog, rows[r].exp_backlog);
            @(posedge clk);
            #1;
        end

`ifdef WRITER_BLANK_GATE_EN
        // Fill to full, then check ready reopens only after the first pop.
        strobe_cnt = 0;
        nacc = 0;
        for (int i = 0; i < 20; i++) begin
            logic acc;
            req_valid = 1'b1;
            req_addr  = 9'(i % 13);
            req_data  = 32'(1000 + i);
            acc       = req_ready;
            @(posedge clk);
            if (acc) begin
                sb_q.push_back('{addr: req_addr, data: req_data});
                nacc++;
            end
            #1;
        end
        req_valid = 1'b0;
        chk("full_accepts", nacc, 16);
        chk("full_ready_low", req_ready, 0);
        chk("full_pending", pending, 16);
        vga_vs = 1'b0;
        @(negedge clk); chk("full_ready_edge_cycle", req_ready, 0);
        @(negedge clk); chk("full_ready_after_pop", req_ready, 1);
        chk("full_pending15", pending, 15);
        @(posedge clk);
        @(posedge clk);
        #1;
        clear_backlog = 1'b1;      // coincides with the budget-ending pop
        @(posedge clk);
        #1;
        clear_backlog = 1'b0;
        vga_vs = 1'b1;
        @(negedge clk);
        chk("set_wins_backlog", backlog, 1);
        chk("full_pending12", pending, 12);
        @(posedge clk);
        #1;
        repeat (3) begin
            vsync_pulse();
            repeat (6) @(posedge clk);
            #1;
        end
        chk("full_drained", pending, 0);
        chk("full_strobes", strobe_cnt, 16);
        chk("full_backlog_sticky", backlog, 1);
        clear_backlog = 1'b1;
        @(posedge clk);
        #1;
        clear_backlog = 1'b0;
        chk("full_backlog_cleared", backlog, 0);

        // Reset in the middle of a drain.
        strobe_cnt = 0;
        for (int i = 0; i < 8; i++) push_one(9'(i), 32'(500 + i));
        vga_vs = 1'b0;
        begin
            int g;
            g = 0;
            while (strobe_cnt < 3 && g < 30) begin
                @(negedge clk);
                #1;
                g++;
            end
        end
        chk("rst_mid_saw3", strobe_cnt, 3);
        reset  = 1'b1;
        vga_vs = 1'b1;
        #1;
        chk("rst_mid_cs", chipselect, 0);
        chk("rst_mid_write", write, 0);
        chk("rst_mid_pending", pending, 0);
        chk("rst_mid_ready", req_ready, 1);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        strobe_cnt = 0;
        vsync_pulse();
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mid_no_more", strobe_cnt, 0);
        chk("rst_mid_pending_after", pending, 0);
`else
        // Reset with entries still queued.
        strobe_cnt = 0;
        push_one(9'd1, 32'd11);
        push_one(9'd2, 32'd22);
        push_one(9'd3, 32'd33);
        reset = 1'b1;
        #1;
        chk("rst_mid_cs", chipselect, 0);
        chk("rst_mid_pending", pending, 0);
        chk("rst_mid_ready", req_ready, 1);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        strobe_cnt = 0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mid_no_more", strobe_cnt, 0);
        chk("rst_mid_backlog", backlog, 0);
`endif

        chk("sb_empty_end", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_reg_writer.md
# vga_reg_writer

Host-side register initiator for the sprite display peripheral. It accepts sprite and score register updates from game logic over a valid/ready port and buffers them in a FIFO. It then issues them as single-cycle chipselect/write transactions on the display peripheral's 9-bit register bus, draining only at the start of vertical sync so that sprite positions never change mid-frame.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- MAX_PER_FRAME, 16: maximum writes issued per vsync; range 1..DEPTH.

Ports:
- clk  in  1  50 MHz system clock; same domain as the display counters.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  update request present.
- req_ready  out  1  FIFO can accept; equals !full.
- req_addr  in  9  target register: 0..9 are sprite x/y pairs, 10 is score, 11 is score_x, 12 is score_y.
- req_data  in  32  register value.
- vga_vs  in  1  active-low vsync from the display counters.
- chipselect  out  1  bus select.
- write  out  1  write strobe; identical to chipselect.
- address  out  9  register address.
- writedata  out  32  register data.
- pending  out  $clog2(DEPTH+1)  current FIFO occupancy.
- backlog  out  1  sticky flag: a drain ended with entries still left.
- clear_backlog  in  1  clears backlog.

## Operation
- Push happens when req_valid && req_ready. req_ready depends only on full, so a pop in the same cycle does not re-open a full FIFO.
- vga_vs is registered once to vs_q. A vsync edge is vs_q==1 && vga_vs==0.
- State machine:
  - IDLE → DRAIN on a vsync edge when the FIFO is not empty. A vsync edge while the FIFO is empty stays in IDLE.
  - DRAIN: each cycle, pop the head and register it to address/writedata with chipselect=write=1. A per-frame counter increments on each write.
  - DRAIN → IDLE when the FIFO becomes empty after a pop, or when the counter reaches MAX_PER_FRAME. The counter clears on entry to DRAIN.
- If DRAIN ends on budget with the FIFO not empty, backlog sets. clear_backlog clears it. When set and clear occur in the same cycle, set wins.
- The slave has no waitrequest: every strobe cycle is one completed write.
- Entries are issued in FIFO order. Duplicate addresses are not merged.
- Reset at any point, including mid-DRAIN, takes effect immediately:
  - FIFO empties and pending goes to 0.
  - State returns to IDLE.
  - No further strobes are issued.

## Timing
- Reset values:
  - chipselect=0, write=0, address=0, writedata=0.
  - backlog=0, pending=0.
  - req_ready=1.
  - vs_q=1.
- When no write is issued, address and writedata hold their last values and chipselect/write are 0.
- If a vsync edge is detected in cycle N, the first strobe is high in cycle N+1. Strobes are back-to-back, one per cycle, up to MAX_PER_FRAME.
- pending updates in the cycle after each push or pop. A simultaneous push and pop leaves pending unchanged.
- A request pushed during DRAIN may be issued in the same drain if it reaches the head before the FIFO empties or the budget runs out.

## Configuration
- WRITER_BLANK_GATE_EN, when defined: vsync-gated draining with the per-frame budget and backlog flag, as described above.
- When not defined:
  - vga_vs and MAX_PER_FRAME are ignored and backlog is tied to 0.
  - The FIFO drains whenever it is not empty.
  - An entry pushed at edge k produces a strobe in the cycle after edge k+1.

## Structure
- Package writer_pkg holds:
  - typedef wr_req_t {addr[8:0], data[31:0]}.
  - state enum {IDLE, DRAIN}.
  - Register address constants: DINO_X=0 … GODZILLA_Y=9, SCORE=10, SCORE_X=11, SCORE_Y=12.
- Sub-module writer_fifo: parameterized DEPTH, first-word-fall-through, with push/pop/full/empty/count ports. Pointers are one bit wider than the index, to distinguish full from empty.

## Test plan
- Push (0,100), (1,50), (10,7), then pulse vga_vs low. Expect three consecutive strobes, starting the cycle after the edge, carrying addr/data 0/100, 1/50, 10/7. pending goes 3→0 and backlog=0.
- With DEPTH=16 and MAX_PER_FRAME=4, push 6 entries and trigger vsync. Expect exactly 4 strobes, then pending=2 and backlog=1. At the next vsync expect 2 strobes. Then assert clear_backlog and expect backlog=0.
- Hold req_valid for 20 cycles with no vsync. Expect req_ready to drop after 16 accepts and pending=16. Trigger vsync: req_ready returns high the cycle after the first pop.
- Trigger vsync with the FIFO empty. Expect no strobe and the state to remain IDLE.
- Push 8 entries, trigger vsync, and assert reset after the 3rd strobe. Expect chipselect=0 immediately, pending=0, req_ready=1, and no further strobes after reset is released.
- Build without WRITER_BLANK_GATE_EN, push (4,200) at edge k. Expect write=1 with address 4 and data 200 in the cycle after edge k+1, with vga_vs held high throughout.
